// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage feeding the instruction decoder. Holds a
//            small writable program memory and a program counter, and presents
//            one registered 8-bit instruction per enabled cycle.
// Ports    : clock, reset      - rising-edge clock, synchronous active-high reset
//            ena               - global enable (low = freeze, output NOP/invalid)
//            prog_we/addr/data - program-memory write port (IDLE/HALT only)
//            run               - start execution from address 0
//            halt_req          - stop execution (RUN only)
//            stall             - downstream not ready, hold output and pc
//            jump_en/jump_addr - redirect pc (one-cycle bubble)
//            instr_out/valid   - registered instruction to decoder
//            pc                - address of the next word to fetch
//            halted            - high in HALT state
// Config   : `define FETCH_HALT_OPCODE_EN makes a fetched 8'hFF halt the
//            program instead of being presented.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int          ADDR_W    = 4,
    parameter logic [7:0]  NOP_INSTR = 8'hE0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ena,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    input  logic              run,
    input  logic              halt_req,
    input  logic              stall,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [7:0]        instr_out,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam int c_depth = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_mem [c_depth];

    logic [7:0] w_fetch;
    logic       w_halt_op;
    logic       w_mem_we;

    assign w_fetch = r_mem[pc];

`ifdef FETCH_HALT_OPCODE_EN
    assign w_halt_op = (w_fetch == 8'hFF);
`else
    assign w_halt_op = 1'b0;
`endif

    // Memory is only writable while not running; it has no reset so the
    // loaded program survives a reset.
    assign w_mem_we = !reset && ena && prog_we && (r_state != S_RUN);

    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            pc          <= '0;
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (!ena) begin
            // Freeze state and pc; output goes idle.
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (halt_req) begin
                        r_state     <= S_HALT;
                        halted      <= 1'b1;
                        instr_out   <= NOP_INSTR;
                        instr_valid <= 1'b0;
                    end else if (jump_en) begin
                        // Jump wins over stall; a bubble precedes the target.
                        pc          <= jump_addr;
                        instr_out   <= NOP_INSTR;
                        instr_valid <= 1'b0;
                    end else if (stall) begin
                        // Hold everything.
                    end else if (w_halt_op) begin
                        r_state     <= S_HALT;
                        halted      <= 1'b1;
                        instr_out   <= NOP_INSTR;
                        instr_valid <= 1'b0;
                    end else begin
                        instr_out   <= w_fetch;
                        instr_valid <= 1'b1;
                        pc          <= pc + 1'b1;
                    end
                end
                default: begin
                    // IDLE and HALT share behaviour apart from the halted flag.
                    instr_out   <= NOP_INSTR;
                    instr_valid <= 1'b0;
                    if (run) begin
                        r_state <= S_RUN;
                        pc      <= '0;
                        halted  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
module tb_fetch_unit;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam logic [7:0] NOP = 8'hE0;

    logic          clock = 1'b0;
    logic          reset, ena, prog_we, run, halt_req, stall, jump_en;
    logic [AW-1:0] prog_addr, jump_addr;
    logic [7:0]    prog_data;
    logic [7:0]    instr_out;
    logic          instr_valid, halted;
    logic [AW-1:0] pc;

    fetch_unit #(.ADDR_W(AW), .NOP_INSTR(NOP)) dut (
        .clock(clock), .reset(reset), .ena(ena), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .run(run),
        .halt_req(halt_req), .stall(stall), .jump_en(jump_en),
        .jump_addr(jump_addr), .instr_out(instr_out),
        .instr_valid(instr_valid), .pc(pc), .halted(halted)
    );

    always #5 clock = ~clock;

    int n_asserts = 0;
    int n_fails   = 0;

    // Reference model: "running" / "halted" flags, an int pc and an array.
    bit         m_running, m_halted;
    int         m_pc;
    logic [7:0] m_out;
    bit         m_valid;
    logic [7:0] m_mem [DEPTH];

    task automatic model_step();
        logic [7:0] w;
        if (reset) begin
            m_running = 0; m_halted = 0; m_pc = 0; m_out = NOP; m_valid = 0;
        end else if (!ena) begin
            m_out = NOP; m_valid = 0;
        end else if (!m_running) begin
            if (prog_we) m_mem[prog_addr] = prog_data;
            m_out = NOP; m_valid = 0;
            if (run) begin m_running = 1; m_halted = 0; m_pc = 0; end
        end else if (halt_req) begin
            m_running = 0; m_halted = 1; m_out = NOP; m_valid = 0;
        end else if (jump_en) begin
            m_pc = int'(jump_addr); m_out = NOP; m_valid = 0;
        end else if (!stall) begin
            w = m_mem[m_pc];
`ifdef FETCH_HALT_OPCODE_EN
            if (w == 8'hFF) begin
                m_running = 0; m_halted = 1; m_out = NOP; m_valid = 0;
            end else begin
                m_out = w; m_valid = 1; m_pc = (m_pc + 1) % DEPTH;
            end
`else
            m_out = w; m_valid = 1; m_pc = (m_pc + 1) % DEPTH;
`endif
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk8("instr_out", instr_out, m_out);
        chk8("instr_valid", {7'd0, instr_valid}, {7'd0, m_valid});
        chk8("pc", {4'd0, pc}, 8'(m_pc));
        chk8("halted", {7'd0, halted}, {7'd0, m_halted});
    endtask

    // Advance one clock, update model, sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        reset = 0; ena = 1; prog_we = 0; run = 0; halt_req = 0;
        stall = 0; jump_en = 0; prog_addr = '0; jump_addr = '0; prog_data = '0;
    endtask

    task automatic write_word(input int a, input logic [7:0] d);
        prog_we = 1; prog_addr = AW'(a); prog_data = d;
        tick();
        prog_we = 0;
    endtask

    initial begin
        logic [7:0] rnd;
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
        #2;
        // Reset
        reset = 1;
        tick(); tick();
        chk8("reset_instr", instr_out, 8'hE0);
        chk8("reset_valid", {7'd0, instr_valid}, 8'd0);
        reset = 0;

        // Program load
        write_word(0, 8'hC5); write_word(1, 8'h03);
        write_word(2, 8'h20); write_word(3, 8'hA1);
        for (int i = 4; i < DEPTH; i++) begin
            rnd = 8'($urandom_range(0, 254));
            write_word(i, rnd);
        end

        // Run and fetch C5, 03
        run = 1; tick(); run = 0;
        chk8("run_pc0", {4'd0, pc}, 8'd0);
        tick(); chk8("first_instr", instr_out, 8'hC5); chk8("first_pc", {4'd0, pc}, 8'd1);
        tick(); chk8("second_instr", instr_out, 8'h03);

        // Stall 3 cycles while 03 is presented
        stall = 1;
        repeat (3) begin
            tick();
            chk8("stall_hold", instr_out, 8'h03);
            chk8("stall_pc", {4'd0, pc}, 8'd2);
        end
        stall = 0;
        tick(); chk8("after_stall", instr_out, 8'h20);
        tick(); chk8("fourth_instr", instr_out, 8'hA1); chk8("fourth_pc", {4'd0, pc}, 8'd4);

        // Jump with simultaneous stall
        jump_en = 1; jump_addr = 0; stall = 1;
        tick(); chk8("jump_bubble", instr_out, 8'hE0);
        jump_en = 0; stall = 0;
        tick(); chk8("jump_target", instr_out, 8'hC5);

        // Advance to pc=5 then drop ena for 2 cycles
        repeat (4) tick();
        chk8("pre_ena_pc", {4'd0, pc}, 8'd5);
        ena = 0;
        repeat (2) begin
            tick();
            chk8("ena_low_valid", {7'd0, instr_valid}, 8'd0);
        end
        ena = 1;
        tick(); chk8("ena_resume_pc", {4'd0, pc}, 8'd6);

        // Wrap: jump to 15, fetch 15 then 0
        jump_en = 1; jump_addr = 4'd15; tick(); jump_en = 0;
        tick(); chk8("wrap_pc", {4'd0, pc}, 8'd0);
        tick(); chk8("wrap_next", instr_out, 8'hC5);

        // Halt, write in HALT, restart
        halt_req = 1; tick(); halt_req = 0;
        chk8("halted_flag", {7'd0, halted}, 8'd1);
        write_word(3, 8'h77);
        write_word(2, 8'hFF);
        run = 1; tick(); run = 0;
        tick(); tick();
        tick();
`ifdef FETCH_HALT_OPCODE_EN
        chk8("ff_halt", {7'd0, halted}, 8'd1);
        chk8("ff_pc", {4'd0, pc}, 8'd2);
`else
        chk8("ff_presented", instr_out, 8'hFF);
        tick(); chk8("hwrite_seen", instr_out, 8'h77);
`endif

        // Reset mid-run keeps the program
        write_word(2, 8'h20);
        run = 1; tick(); run = 0;
        tick(); tick();
        reset = 1; tick(); reset = 0;
        run = 1; tick(); run = 0;
        tick(); chk8("retained", instr_out, 8'hC5);

        // Randomized phase
        for (int c = 0; c < 600; c++) begin
            reset    = ($urandom_range(0, 99) < 2);
            ena      = ($urandom_range(0, 99) < 90);
            run      = ($urandom_range(0, 99) < 10);
            halt_req = ($urandom_range(0, 99) < 4);
            jump_en  = ($urandom_range(0, 99) < 10);
            stall    = ($urandom_range(0, 99) < 20);
            prog_we  = !reset && ($urandom_range(0, 99) < 30);
            prog_addr = AW'($urandom_range(0, DEPTH - 1));
            jump_addr = AW'($urandom_range(0, DEPTH - 1));
            prog_data = 8'($urandom_range(0, 255));
            tick();
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

    initial begin
        #200000;
        n_fails++;
        $display("FAIL timeout: observed no finish expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
